// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the radix-2 DIT FFT butterfly sequencer.
// Default sizing constants describe the 16-point build.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } fft_state_t;

  // Bits needed to index n distinct values, never less than one.
  function automatic int bit_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int FFT_POINTS_DEF = 16;
  localparam int LOG2_N         = $clog2(FFT_POINTS_DEF);
  localparam int STAGE_W        = bit_width(LOG2_N);

endpackage

// File: rtl/fft_bfly_addr_calc.sv
// Combinational butterfly address and twiddle-index generator for stage s, butterfly b.
// Zero latency; the parent registers the results.
module fft_bfly_addr_calc
  import fft_pkg::*;
#(
  parameter int FFT_POINTS = 16
) (
  input  logic [bit_width($clog2(FFT_POINTS))-1:0] i_s,
  input  logic [$clog2(FFT_POINTS)-2:0]            i_b,
  output logic [$clog2(FFT_POINTS)-1:0]            o_addr_a,
  output logic [$clog2(FFT_POINTS)-1:0]            o_addr_b,
  output logic [$clog2(FFT_POINTS)-1:0]            o_twiddle_idx
);

  localparam int L2N = $clog2(FFT_POINTS);
  localparam int SW  = bit_width(L2N);
  localparam logic [SW-1:0] TOP_S = SW'(L2N - 1);

  logic [L2N-1:0] w_b;
  logic [L2N-1:0] w_half;
  logic [L2N-1:0] w_pos;
  logic [L2N-1:0] w_grp;
  logic [SW-1:0]  w_tw_sh;

  assign w_b     = {1'b0, i_b};
  assign w_half  = L2N'(1) << i_s;
  assign w_pos   = w_b & (w_half - L2N'(1));
  assign w_grp   = w_b >> i_s;
  assign w_tw_sh = TOP_S - i_s;

  // Each group spans 2*half points; the pair is split by half.
  assign o_addr_a      = ((w_grp << i_s) << 1) | w_pos;
  assign o_addr_b      = o_addr_a + w_half;
  assign o_twiddle_idx = w_pos << w_tw_sh;

endmodule

// File: rtl/fft_bfly_sequencer.sv
// Walks all stages/butterflies of an in-place radix-2 DIT FFT, one descriptor per handshake.
// First descriptor one cycle after start; descriptor holds while out_ready is low; idle gap between stages.
module fft_bfly_sequencer
  import fft_pkg::*;
#(
  parameter int FFT_POINTS = 16,
  parameter int STAGE_GAP  = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [$clog2(FFT_POINTS)-1:0]            addr_a,
  output logic [$clog2(FFT_POINTS)-1:0]            addr_b,
  output logic [$clog2(FFT_POINTS)-1:0]            twiddle_idx,
  output logic [bit_width($clog2(FFT_POINTS))-1:0] stage,
  output logic                                     last,
  output logic                                     busy,
  output logic                                     done
);

  localparam int L2N = $clog2(FFT_POINTS);
  localparam int SW  = bit_width(L2N);
  localparam int BW  = L2N - 1;
  localparam int GW  = bit_width(STAGE_GAP);
  localparam logic [SW-1:0] LAST_S   = SW'(L2N - 1);
  localparam logic [BW-1:0] LAST_B   = BW'(FFT_POINTS / 2 - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  fft_state_t     r_state;
  fft_state_t     w_nxt_state;
  logic [SW-1:0]  r_s;
  logic [SW-1:0]  w_nxt_s;
  logic [BW-1:0]  r_b;
  logic [BW-1:0]  w_nxt_b;
  logic [GW-1:0]  r_gap;
  logic [GW-1:0]  w_nxt_gap;
  logic           w_hs;

  logic           r_valid;
  logic           r_last;
  logic           r_busy;
  logic           r_done;
  logic [L2N-1:0] r_addr_a;
  logic [L2N-1:0] r_addr_b;
  logic [L2N-1:0] r_tw;
  logic [L2N-1:0] w_addr_a;
  logic [L2N-1:0] w_addr_b;
  logic [L2N-1:0] w_tw;

  assign w_hs = r_valid & out_ready;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_s     = r_s;
    w_nxt_b     = r_b;
    w_nxt_gap   = r_gap;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_state = RUN;
          w_nxt_s     = '0;
          w_nxt_b     = '0;
        end
      end
      RUN: begin
        if (w_hs) begin
          if (r_b != LAST_B) begin
            w_nxt_b = r_b + BW'(1);
          end else if (r_s != LAST_S) begin
            w_nxt_b = '0;
            w_nxt_s = r_s + SW'(1);
            if (STAGE_GAP > 0) begin
              w_nxt_state = GAP;
              w_nxt_gap   = GAP_LOAD;
            end
          end else begin
            w_nxt_state = DONE;
          end
        end
      end
      GAP: begin
        if (r_gap == '0) begin
          w_nxt_state = RUN;
        end else begin
          w_nxt_gap = r_gap - GW'(1);
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // Addresses follow the next descriptor so they land in the same cycle as out_valid.
  fft_bfly_addr_calc #(
    .FFT_POINTS(FFT_POINTS)
  ) u_addr_calc (
    .i_s          (w_nxt_s),
    .i_b          (w_nxt_b),
    .o_addr_a     (w_addr_a),
    .o_addr_b     (w_addr_b),
    .o_twiddle_idx(w_tw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_b      <= '0;
      r_gap    <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_tw     <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_s      <= w_nxt_s;
      r_b      <= w_nxt_b;
      r_gap    <= w_nxt_gap;
      r_valid  <= (w_nxt_state == RUN);
      r_last   <= (w_nxt_state == RUN) && (w_nxt_s == LAST_S) && (w_nxt_b == LAST_B);
      r_busy   <= (w_nxt_state == RUN) || (w_nxt_state == GAP);
      r_done   <= (w_nxt_state == DONE);
      r_addr_a <= w_addr_a;
      r_addr_b <= w_addr_b;
      r_tw     <= w_tw;
    end
  end

  assign out_valid   = r_valid;
  assign addr_a      = r_addr_a;
  assign addr_b      = r_addr_b;
  assign twiddle_idx = r_tw;
  assign stage       = r_s;
  assign last        = r_last;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
